spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// ============================================================================
// Module   : spi_arbiter
// Brief    : Two-requester round-robin arbiter in front of one spi_controller,
//            with idle-owner timeout, grant lockout and receive-drain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        wr0,
    input  logic        wr1,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    input  logic        ign0,
    input  logic        ign1,
    input  logic        rd0,
    input  logic        rd1,
    output logic        avail0,
    output logic        avail1,
    output logic        full0,
    output logic        full1,
    output logic [7:0]  rx_dout,
    output logic        spi_wr,
    output logic        spi_rd,
    output logic        spi_ignore_response,
    output logic [7:0]  spi_din,
    input  logic        spi_data_avail,
    input  logic        spi_buffer_empty,
    input  logic        spi_buffer_full,
    input  logic [7:0]  spi_dout,
    output logic        timeout_err,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] c_IDLE_MAX = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_last;      // 1: requester 1 owned the bus most recently
    logic        r_lock0;
    logic        r_lock1;
    logic [15:0] r_idle_cnt;
    logic        r_timeout_err;
    logic [15:0] r_drop_cnt;

    logic w_own0;
    logic w_own1;
    logic w_elig0;
    logic w_elig1;
    logic w_owner_req;
    logic w_owner_act;
    logic w_expired;

    assign w_own0      = (r_state == ST_OWN0);
    assign w_own1      = (r_state == ST_OWN1);
    assign w_elig0     = req0 & ~r_lock0;
    assign w_elig1     = req1 & ~r_lock1;
    assign w_owner_req = w_own1 ? req1 : req0;
    assign w_owner_act = w_own1 ? (wr1 | rd1) : (wr0 | rd0);
    // Owner activity in the final idle cycle still rescues the grant.
    assign w_expired   = (r_idle_cnt >= c_IDLE_MAX) & ~w_owner_act;

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state       <= ST_IDLE;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_last        <= 1'b1;
            r_lock0       <= 1'b0;
            r_lock1       <= 1'b0;
            r_idle_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
            r_drop_cnt    <= 16'd0;
        end else begin
            r_timeout_err <= 1'b0;
            if (!req0) r_lock0 <= 1'b0;
            if (!req1) r_lock1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= 16'd0;
                    if (w_elig0 && (!w_elig1 || r_last)) begin
                        r_state <= ST_OWN0;
                        r_gnt0  <= 1'b1;
                    end else if (w_elig1) begin
                        r_state <= ST_OWN1;
                        r_gnt1  <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (!w_owner_req || w_expired) begin
                        r_state <= ST_DRAIN;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_last  <= w_own1;
                        // A normal release takes precedence over a coincident timeout.
                        if (w_owner_req) begin
                            r_timeout_err <= 1'b1;
                            if (w_own1) r_lock1 <= 1'b1;
                            else        r_lock0 <= 1'b1;
                        end
                    end else if (w_owner_act) begin
                        r_idle_cnt <= 16'd0;
                    end else if (r_idle_cnt < c_IDLE_MAX) begin
                        r_idle_cnt <= r_idle_cnt + 16'd1;
                    end
                end
                default: begin
                    if (spi_data_avail && (r_drop_cnt != 16'hFFFF))
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    if (spi_buffer_empty && !spi_data_avail)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        spi_wr              = 1'b0;
        spi_rd              = 1'b0;
        spi_din             = 8'd0;
        spi_ignore_response = 1'b0;
        case (r_state)
            ST_OWN0: begin
                spi_wr              = wr0 & ~spi_buffer_full & ~Rst;
                spi_rd              = rd0 & spi_data_avail & ~Rst;
                spi_din             = din0;
                spi_ignore_response = ign0;
            end
            ST_OWN1: begin
                spi_wr              = wr1 & ~spi_buffer_full & ~Rst;
                spi_rd              = rd1 & spi_data_avail & ~Rst;
                spi_din             = din1;
                spi_ignore_response = ign1;
            end
            ST_DRAIN: spi_rd = spi_data_avail & ~Rst;
            default:  spi_rd = 1'b0;
        endcase
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign avail0      = spi_data_avail & r_gnt0;
    assign avail1      = spi_data_avail & r_gnt1;
    assign full0       = spi_buffer_full | ~r_gnt0;
    assign full1       = spi_buffer_full | ~r_gnt1;
    assign rx_dout     = spi_dout;
    assign timeout_err = r_timeout_err;
    assign drop_cnt    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Vector table, directed corner sequences and randomized run of
//            spi_arbiter against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_arbiter;

    localparam int c_TIMEOUT = 8;

    typedef struct packed {
        bit       rst, q0, q1, w0, w1, r0, r1, i0, i1, full, av, emp;
        bit [7:0] d0, d1, dout;
    } in_t;

    typedef struct packed {
        in_t      in;
        bit       g0, g1, f0, a1, swr, srd;
        bit [7:0] sdin;
        bit       terr;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Rst, req0, req1, wr0, wr1, ign0, ign1, rd0, rd1;
    logic [7:0]  din0, din1, spi_dout;
    logic        spi_data_avail, spi_buffer_empty, spi_buffer_full;
    logic        gnt0, gnt1, avail0, avail1, full0, full1;
    logic        spi_wr, spi_rd, spi_ignore_response, timeout_err;
    logic [7:0]  rx_dout, spi_din;
    logic [15:0] drop_cnt;

    spi_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .Rst(Rst),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .wr0(wr0), .wr1(wr1), .din0(din0), .din1(din1),
        .ign0(ign0), .ign1(ign1), .rd0(rd0), .rd1(rd1),
        .avail0(avail0), .avail1(avail1), .full0(full0), .full1(full1),
        .rx_dout(rx_dout), .spi_wr(spi_wr), .spi_rd(spi_rd),
        .spi_ignore_response(spi_ignore_response), .spi_din(spi_din),
        .spi_data_avail(spi_data_avail), .spi_buffer_empty(spi_buffer_empty),
        .spi_buffer_full(spi_buffer_full), .spi_dout(spi_dout),
        .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner is -1 (nobody), 0, 1, or 2 (draining).
    int  m_own  = -1;
    bit  m_last = 1'b1;
    bit  m_lock [2];
    int  m_idle = 0;
    bit  m_terr = 1'b0;
    int  m_drop = 0;
    in_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mi(bit rst, bit q0, bit q1, bit w0, bit w1, bit r0, bit r1,
                               bit full, bit av, bit emp, bit [7:0] d0, bit [7:0] d1);
        in_t v;
        v = '0;
        v.rst = rst; v.q0 = q0; v.q1 = q1; v.w0 = w0; v.w1 = w1; v.r0 = r0; v.r1 = r1;
        v.full = full; v.av = av; v.emp = emp; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    function automatic rec_t mr(in_t v, bit g0, bit g1, bit f0, bit a1, bit swr, bit srd,
                                bit [7:0] sdin, bit terr);
        rec_t r;
        r.in = v; r.g0 = g0; r.g1 = g1; r.f0 = f0; r.a1 = a1;
        r.swr = swr; r.srd = srd; r.sdin = sdin; r.terr = terr;
        return r;
    endfunction

    task automatic drive(input in_t v);
        cur = v;
        Rst = v.rst; req0 = v.q0; req1 = v.q1; wr0 = v.w0; wr1 = v.w1;
        rd0 = v.r0; rd1 = v.r1; ign0 = v.i0; ign1 = v.i1;
        spi_buffer_full = v.full; spi_data_avail = v.av; spi_buffer_empty = v.emp;
        din0 = v.d0; din1 = v.d1; spi_dout = v.dout;
        #1;
        check_model();
    endtask

    task automatic check_model();
        bit own0, own1, e_wr, e_rd;
        bit [7:0] e_din;
        bit e_ign;
        own0  = (m_own == 0);
        own1  = (m_own == 1);
        e_wr  = !cur.rst && ((own0 && cur.w0) || (own1 && cur.w1)) && !cur.full;
        e_rd  = !cur.rst && cur.av && ((own0 && cur.r0) || (own1 && cur.r1) || m_own == 2);
        e_din = own0 ? cur.d0 : (own1 ? cur.d1 : 8'd0);
        e_ign = own0 ? cur.i0 : (own1 ? cur.i1 : 1'b0);
        chk("m_gnt0", gnt0, own0);
        chk("m_gnt1", gnt1, own1);
        chk("m_avail0", avail0, cur.av && own0);
        chk("m_avail1", avail1, cur.av && own1);
        chk("m_full0", full0, cur.full || !own0);
        chk("m_full1", full1, cur.full || !own1);
        chk("m_spi_wr", spi_wr, e_wr);
        chk("m_spi_rd", spi_rd, e_rd);
        chk("m_spi_din", spi_din, e_din);
        chk("m_spi_ign", spi_ignore_response, e_ign);
        chk("m_rx_dout", rx_dout, cur.dout);
        chk("m_timeout_err", timeout_err, m_terr);
        chk("m_drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic model_update();
        bit e0, e1, rq, act;
        if (cur.rst) begin
            m_own = -1; m_last = 1'b1; m_lock[0] = 0; m_lock[1] = 0;
            m_idle = 0; m_terr = 0; m_drop = 0;
            return;
        end
        m_terr = 0;
        if (m_own == -1) begin
            e0 = cur.q0 && !m_lock[0];
            e1 = cur.q1 && !m_lock[1];
            if (e0 && e1) m_own = m_last ? 0 : 1;
            else if (e0)  m_own = 0;
            else if (e1)  m_own = 1;
            m_idle = 0;
        end else if (m_own == 2) begin
            if (cur.av && m_drop < 65535) m_drop++;
            if (cur.emp && !cur.av) m_own = -1;
        end else begin
            rq  = (m_own == 1) ? cur.q1 : cur.q0;
            act = (m_own == 1) ? (cur.w1 || cur.r1) : (cur.w0 || cur.r0);
            if (!rq) begin
                m_last = (m_own == 1); m_own = 2;
            end else if (m_idle >= c_TIMEOUT - 1 && !act) begin
                m_lock[m_own] = 1; m_last = (m_own == 1); m_terr = 1; m_own = 2;
            end else begin
                m_idle = act ? 0 : m_idle + 1;
            end
        end
        if (!cur.q0) m_lock[0] = 0;
        if (!cur.q1) m_lock[1] = 0;
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step(input in_t v);
        drive(v);
        adv();
    endtask

    task automatic do_reset();
        step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00));
        step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00));
    endtask

    rec_t tbl [13];
    int   gcnt, tcnt;
    in_t  rv;
    bit   lowact;

    initial begin
        // Arbitration, write path, full gating, non-owner masking, reset gating.
        tbl[0]  = mr(mi(1,0,0,0,0,0,0,0,0,1,8'h00,8'h00), 0,0,1,0,0,0,8'h00,0);
        tbl[1]  = mr(mi(0,1,1,0,0,0,0,0,0,1,8'h00,8'h00), 0,0,1,0,0,0,8'h00,0);
        tbl[2]  = mr(mi(0,1,1,1,0,0,0,0,0,1,8'hA5,8'h00), 1,0,0,0,1,0,8'hA5,0);
        tbl[3]  = mr(mi(0,1,1,0,1,0,0,0,0,1,8'h11,8'h77), 1,0,0,0,0,0,8'h11,0);
        tbl[4]  = mr(mi(0,1,1,1,0,0,0,0,0,1,8'h3C,8'h00), 1,0,0,0,1,0,8'h3C,0);
        tbl[5]  = mr(mi(0,1,1,1,0,0,0,1,0,1,8'hFF,8'h00), 1,0,1,0,0,0,8'hFF,0);
        tbl[6]  = mr(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00), 1,0,0,0,0,0,8'h00,0);
        tbl[7]  = mr(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00), 0,0,1,0,0,0,8'h00,0);
        tbl[8]  = mr(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00), 0,0,1,0,0,0,8'h00,0);
        tbl[9]  = mr(mi(0,0,1,0,0,0,1,0,1,0,8'h00,8'h5A), 0,1,1,1,0,1,8'h5A,0);
        tbl[10] = mr(mi(0,0,1,0,0,1,0,0,1,0,8'h00,8'h00), 0,1,1,1,0,0,8'h00,0);
        tbl[11] = mr(mi(1,0,1,0,1,0,1,0,1,0,8'h00,8'h00), 0,1,1,1,0,0,8'h00,0);
        tbl[12] = mr(mi(0,0,0,0,0,0,0,0,0,1,8'h00,8'h00), 0,0,1,0,0,0,8'h00,0);
        m_lock[0] = 0; m_lock[1] = 0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].in);
            chk($sformatf("t%0d_gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("t%0d_gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("t%0d_full0", i), full0, tbl[i].f0);
            chk($sformatf("t%0d_avail1", i), avail1, tbl[i].a1);
            chk($sformatf("t%0d_spi_wr", i), spi_wr, tbl[i].swr);
            chk($sformatf("t%0d_spi_rd", i), spi_rd, tbl[i].srd);
            chk($sformatf("t%0d_spi_din", i), spi_din, tbl[i].sdin);
            chk($sformatf("t%0d_terr", i), timeout_err, tbl[i].terr);
            adv();
        end

        // Release with three bytes pending: all popped and counted in drain.
        do_reset();
        step(mi(0,1,0,0,0,0,0,0,0,1,8'h00,8'h00));
        drive(mi(0,1,0,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s4_gnt0", gnt0, 1'b1);
        adv();
        drive(mi(0,0,0,0,0,0,0,0,1,0,8'h00,8'h00));
        chk("s4_no_rd_owner", spi_rd, 1'b0);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(mi(0,0,0,0,0,0,0,0,1,0,8'h00,8'h00));
            chk("s4_drain_rd", spi_rd, 1'b1);
            adv();
        end
        drive(mi(0,0,0,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s4_drop_cnt", drop_cnt, 16'd3);
        chk("s4_rd_done", spi_rd, 1'b0);
        adv();

        // Reset during ownership: immediate abort to idle, counters cleared.
        step(mi(0,1,0,0,0,0,0,0,0,1,8'h00,8'h00));
        drive(mi(0,1,0,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s6_gnt0_before", gnt0, 1'b1);
        adv();
        step(mi(1,1,0,0,0,0,0,0,0,1,8'h00,8'h00));
        drive(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s6_gnt0_after", gnt0, 1'b0);
        chk("s6_drop_cnt", drop_cnt, 16'd0);
        adv();
        drive(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s6_idle_regrant", gnt1, 1'b1);
        adv();

        // Idle owner timeout and lockout until req toggles low.
        do_reset();
        gcnt = 0; tcnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
            gcnt += int'(gnt1);
            tcnt += int'(timeout_err);
            adv();
        end
        chk("s5_gnt_cycles", gcnt, c_TIMEOUT);
        chk("s5_terr_pulses", tcnt, 1);
        for (int i = 0; i < 3; i++) begin
            drive(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
            chk("s5_locked", gnt1, 1'b0);
            adv();
        end
        step(mi(0,0,0,0,0,0,0,0,0,1,8'h00,8'h00));
        step(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
        drive(mi(0,0,1,0,0,0,0,0,0,1,8'h00,8'h00));
        chk("s5_regrant", gnt1, 1'b1);
        adv();

        // Randomized traffic against the model.
        do_reset();
        rv = mi(0,0,0,0,0,0,0,0,0,1,8'h00,8'h00);
        for (int i = 0; i < 3000; i++) begin
            lowact = ((i / 200) % 2) == 1;
            rv.rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) rv.q0 = ~rv.q0;
            if ($urandom_range(0, 7) == 0) rv.q1 = ~rv.q1;
            rv.w0   = lowact ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0);
            rv.w1   = lowact ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0);
            rv.r0   = lowact ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0);
            rv.r1   = lowact ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 2) == 0);
            rv.i0   = $urandom_range(0, 1) == 1;
            rv.i1   = $urandom_range(0, 1) == 1;
            rv.full = $urandom_range(0, 3) == 0;
            rv.av   = $urandom_range(0, 2) == 0;
            rv.emp  = $urandom_range(0, 1) == 1;
            rv.d0   = 8'($urandom);
            rv.d1   = 8'($urandom);
            rv.dout = 8'($urandom);
            step(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
